// File: rtl/riscv_pkg.sv
// Shared control-unit definitions: FSM states, base opcodes, ALU and immediate
// select codes, reused by the multicycle control FSM and its ALU decoder.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    UPPER    = 4'd11,
    FAULT    = 4'd12
  } state_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_ITYPE  = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_OR  = 4'b1011;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b0100;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUREG = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  // Only BEQ and BNE redirect the PC; every other branch funct3 falls through.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic eq);
    logic taken;
    case (funct3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from opcode/funct3/funct7; SUB is reserved for R-type
// so that I-type immediates with bit 30 set still add.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  output logic [3:0] alu_ctrl
);

  logic is_rtype_s;

  assign is_rtype_s = (opcode == OP_RTYPE);

  // funct3 to ALU operation
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (funct3)
      3'b000: begin
        if (is_rtype_s && funct7) begin
          alu_ctrl = ALU_SUB;
        end else begin
          alu_ctrl = ALU_ADD;
        end
      end
      3'b001:  alu_ctrl = ALU_SLL;
      3'b100:  alu_ctrl = ALU_XOR;
      3'b101:  alu_ctrl = ALU_SRL;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control unit: unified-memory fetch with timeout, opcode
// dispatch, and per-state datapath select/enable generation.
module mc_control_fsm
  import riscv_pkg::*;
#(
  parameter int IMEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       EQ,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUctrl,
  output logic [2:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic       fault
);

  localparam int CNT_W = $clog2(IMEM_WAIT_MAX + 2);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [3:0]       alu_dec_s;
  logic             is_store_s;
  logic             is_jalr_s;
  logic             is_jal_s;
  logic             is_lui_s;
  logic             fetch_timeout_s;

  assign is_store_s      = (opcode == OP_STORE);
  assign is_jalr_s       = (opcode == OP_JALR);
  assign is_jal_s        = (opcode == OP_JAL);
  assign is_lui_s        = (opcode == OP_LUI);
  assign fetch_timeout_s = (wait_cnt_r == CNT_W'(IMEM_WAIT_MAX));

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (alu_dec_s)
  );

  // State register and fetch wait counter (counter restarts on every FETCH entry)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      wait_cnt_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == FETCH) && (state_nxt_s == FETCH)) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
      end else begin
        wait_cnt_r <= '0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH: begin
        if (mem_ready) begin
          state_nxt_s = DECODE;
        end else if (fetch_timeout_s) begin
          state_nxt_s = FAULT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt_s = MEMADR;
          OP_RTYPE:          state_nxt_s = EXECR;
          OP_ITYPE:          state_nxt_s = EXECI;
          OP_BRANCH:         state_nxt_s = BRANCH;
          OP_JAL, OP_JALR:   state_nxt_s = JUMP;
          OP_LUI, OP_AUIPC:  state_nxt_s = UPPER;
          default:           state_nxt_s = FAULT;
        endcase
      end
      MEMADR: begin
        if (is_store_s) begin
          state_nxt_s = MEMWRITE;
        end else begin
          state_nxt_s = MEMREAD;
        end
      end
      MEMREAD: begin
        if (mem_ready) begin
          state_nxt_s = MEMWB;
        end else begin
          state_nxt_s = MEMREAD;
        end
      end
      MEMWRITE: begin
        if (mem_ready) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = MEMWRITE;
        end
      end
      EXECR, EXECI, UPPER:        state_nxt_s = ALUWB;
      MEMWB, ALUWB, BRANCH, JUMP: state_nxt_s = FETCH;
      FAULT:                      state_nxt_s = FAULT;
      default:                    state_nxt_s = FAULT;
    endcase
  end

  // Output decode; everything is forced to zero while rst is high
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUctrl   = ALU_ADD;
    ImmSrc    = IMM_I;
    ResultSrc = RES_ALUREG;
    fault     = 1'b0;
    if (rst) begin
      fault = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE: begin
          // JALR needs rs1+imm ready for JUMP; all others precompute oldPC+imm
          ALUSrcB = SRCB_IMM;
          if (is_jalr_s) begin
            ALUSrcA = SRCA_RS1;
            ImmSrc  = IMM_I;
          end else if (is_jal_s) begin
            ALUSrcA = SRCA_OLDPC;
            ImmSrc  = IMM_J;
          end else begin
            ALUSrcA = SRCA_OLDPC;
            ImmSrc  = IMM_B;
          end
        end
        MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = is_store_s ? IMM_S : IMM_I;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        MEMWRITE: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        MEMWB: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_MEM;
        end
        EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUctrl = alu_dec_s;
        end
        EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_I;
          ALUctrl = alu_dec_s;
        end
        ALUWB: begin
          RegWrite  = 1'b1;
          ResultSrc = RES_ALUREG;
        end
        BRANCH: begin
          ALUSrcA   = SRCA_RS1;
          ALUSrcB   = SRCB_RS2;
          ALUctrl   = ALU_SUB;
          PCWrite   = branch_taken(funct3, EQ);
          ResultSrc = RES_ALUREG;
        end
        JUMP: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
          ResultSrc = RES_ALUOUT;
          ImmSrc    = is_jalr_s ? IMM_I : IMM_J;
        end
        UPPER: begin
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_U;
          if (is_lui_s) begin
            ALUSrcA = SRCA_PC;
            ALUctrl = ALU_LUI;
          end else begin
            ALUSrcA = SRCA_OLDPC;
            ALUctrl = ALU_ADD;
          end
        end
        FAULT:   fault = 1'b1;
        default: fault = 1'b1;
      endcase
    end
  end

endmodule
